// File: rtl/alu_uart_frontend_pkg.sv
// alu_uart_frontend_pkg: operator byte codes, ALU opcodes, FSM states and default error byte
package alu_uart_frontend_pkg;
  localparam logic [7:0] ERR_CODE_DEF = 8'hEE;
  localparam logic [7:0] C_ADD = 8'h2B;
  localparam logic [7:0] C_SUB = 8'h2D;
  localparam logic [7:0] C_AND = 8'h26;
  localparam logic [7:0] C_OR  = 8'h7C;
  localparam logic [7:0] C_XOR = 8'h5E;
  localparam logic [7:0] C_NOR = 8'h7E;
  localparam logic [7:0] C_SRL = 8'h3E;
  localparam logic [7:0] C_SLL = 8'h3C;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SLL, OP_INV} opcode_t;
  typedef enum logic [2:0] {S_RX_A, S_RX_OP, S_RX_B, S_EXEC, S_TX_LOAD, S_TX_WAIT} state_t;
  // Wide input so any NB_BYTE can be zero-extended into it; bytes with extra high bits decode as invalid.
  function automatic opcode_t decode_op(input logic [31:0] b);
    return b == 32'(C_ADD) ? OP_ADD :
           b == 32'(C_SUB) ? OP_SUB :
           b == 32'(C_AND) ? OP_AND :
           b == 32'(C_OR)  ? OP_OR  :
           b == 32'(C_XOR) ? OP_XOR :
           b == 32'(C_NOR) ? OP_NOR :
           b == 32'(C_SRL) ? OP_SRL :
           b == 32'(C_SLL) ? OP_SLL : OP_INV;
  endfunction
endpackage

// File: rtl/alu_uart_frontend_if.sv
// alu_uart_frontend_if: UART-side bus of the ALU frontend
//   i_rx_data/i_rx_done : received byte and RX done level
//   i_tx_done           : TX done level
//   o_tx_data/o_tx_start: byte to send and its one-cycle request
//   o_busy/o_frame_err  : computing/transmitting flag, timeout discard pulse
interface alu_uart_frontend_if #(parameter int NB_BYTE = 8);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_frame_err;
  modport slave  (input  i_rx_data, i_rx_done, i_tx_done, output o_tx_data, o_tx_start, o_busy, o_frame_err);
  modport master (output i_rx_data, i_rx_done, i_tx_done, input  o_tx_data, o_tx_start, o_busy, o_frame_err);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational NB_OP-bit ALU; i_a, i_b, i_op in -> o_res, o_valid (operator known) out
module alu_core import alu_uart_frontend_pkg::*; #(
  parameter int NB_OP = 16
) (
  input  logic [NB_OP-1:0] i_a,
  input  logic [NB_OP-1:0] i_b,
  input  opcode_t          i_op,
  output logic [NB_OP-1:0] o_res,
  output logic             o_valid
);
  localparam int SW = $clog2(NB_OP);
  logic [SW-1:0] w_sh;
  assign w_sh    = i_b[SW-1:0];
  assign o_valid = i_op != OP_INV;
  always_comb begin
    o_res = '0;
    case (i_op)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_NOR:  o_res = ~(i_a | i_b);
      OP_SRL:  o_res = i_a >> w_sh;
      OP_SLL:  o_res = i_a << w_sh;
      default: o_res = '0;
    endcase
  end
endmodule

// File: rtl/alu_uart_frontend.sv
// alu_uart_frontend: receives A, operator, B over UART bytes, computes, replies with the result MSB first
//   i_clk, i_rst : clock and synchronous active-high reset
//   bus (slave)  : UART RX/TX handshake, busy flag and frame-error pulse
module alu_uart_frontend import alu_uart_frontend_pkg::*; #(
  parameter int                 NB_BYTE  = 8,
  parameter int                 N_BYTES  = 2,
  parameter int                 TIMEOUT  = 100000,
  parameter logic [NB_BYTE-1:0] ERR_CODE = NB_BYTE'(ERR_CODE_DEF)
) (
  input logic                i_clk,
  input logic                i_rst,
  alu_uart_frontend_if.slave bus
);
  localparam int NB_OP = NB_BYTE * N_BYTES;
  localparam int CW    = $clog2(N_BYTES + 1);
  localparam int TW    = $clog2(TIMEOUT + 2);
  state_t             r_state, w_next;
  logic [NB_OP-1:0]   r_a, r_b, r_res, w_res;
  logic [NB_BYTE-1:0] r_op;
  logic               r_valid, w_valid;
  logic [CW-1:0]      r_cnt;
  logic [TW-1:0]      r_to;
  logic               r_rx_prev, r_tx_prev;
  logic               w_rx_edge, w_tx_edge, w_rx_st, w_accept, w_run, w_expire, w_last_in, w_last_out, w_done;
  alu_core #(.NB_OP(NB_OP)) u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_op   (decode_op(32'(r_op))),
    .o_res  (w_res),
    .o_valid(w_valid)
  );
  assign w_rx_edge  = bus.i_rx_done & ~r_rx_prev;
  assign w_tx_edge  = bus.i_tx_done & ~r_tx_prev;
  assign w_rx_st    = r_state == S_RX_A || r_state == S_RX_OP || r_state == S_RX_B;
  assign w_accept   = w_rx_edge && w_rx_st;
  // The timeout only runs once the frame has started, i.e. anywhere past the first byte of A.
  assign w_run      = TIMEOUT != 0 && w_rx_st && (r_state != S_RX_A || r_cnt != '0);
  assign w_expire   = w_run && !w_accept && r_to == TW'(TIMEOUT);
  assign w_last_in  = r_cnt == CW'(N_BYTES - 1);
  assign w_last_out = !r_valid || w_last_in;
  assign w_done     = r_state == S_TX_WAIT && w_tx_edge && w_last_out;
  always_ff @(posedge i_clk) r_state <= i_rst ? S_RX_A : w_next;
  always_comb begin
    w_next = r_state;
    if (w_expire) w_next = S_RX_A;
    else case (r_state)
      S_RX_A:    w_next = (w_accept && w_last_in) ? S_RX_OP : S_RX_A;
      S_RX_OP:   w_next = w_accept ? S_RX_B : S_RX_OP;
      S_RX_B:    w_next = (w_accept && w_last_in) ? S_EXEC : S_RX_B;
      S_EXEC:    w_next = S_TX_LOAD;
      S_TX_LOAD: w_next = S_TX_WAIT;
      S_TX_WAIT: w_next = w_tx_edge ? (w_last_out ? S_RX_A : S_TX_LOAD) : S_TX_WAIT;
      default:   w_next = S_RX_A;
    endcase
  end
  always_comb begin
    bus.o_busy      = r_state == S_EXEC || r_state == S_TX_LOAD || r_state == S_TX_WAIT;
    bus.o_tx_start  = r_state == S_TX_LOAD;
    bus.o_tx_data   = (r_state == S_TX_LOAD || r_state == S_TX_WAIT) ? (r_valid ? r_res[NB_OP-1 -: NB_BYTE] : ERR_CODE) : '0;
    bus.o_frame_err = w_expire;
  end
  // r_res shifts left after each sent byte so the outgoing byte is always its top slice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_res     <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_to      <= '0;
      r_rx_prev <= 1'b0;
      r_tx_prev <= 1'b0;
    end else begin
      r_rx_prev <= bus.i_rx_done;
      r_tx_prev <= bus.i_tx_done;
      r_to      <= (w_run && !w_accept && !w_expire) ? r_to + 1'b1 : '0;
      if (w_expire || w_done) begin
        r_a   <= '0;
        r_b   <= '0;
        r_op  <= '0;
        r_cnt <= '0;
      end else if (w_accept && r_state == S_RX_A) begin
        r_a   <= (r_a << NB_BYTE) | NB_OP'(bus.i_rx_data);
        r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
      end else if (w_accept && r_state == S_RX_OP) begin
        r_op <= bus.i_rx_data;
      end else if (w_accept && r_state == S_RX_B) begin
        r_b   <= (r_b << NB_BYTE) | NB_OP'(bus.i_rx_data);
        r_cnt <= w_last_in ? '0 : r_cnt + 1'b1;
      end else if (r_state == S_EXEC) begin
        r_res   <= w_res;
        r_valid <= w_valid;
        r_cnt   <= '0;
      end else if (r_state == S_TX_WAIT && w_tx_edge) begin
        r_res <= r_res << NB_BYTE;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_uart_frontend.sv
// tb_alu_uart_frontend: directed self-checking bench for alu_uart_frontend (N_BYTES=2, short timeout)
module tb_alu_uart_frontend;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  alu_uart_frontend_if #(.NB_BYTE(8)) bus ();
  alu_uart_frontend #(.NB_BYTE(8), .N_BYTES(2), .TIMEOUT(TO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic put_byte(input logic [7:0] d);
    @(negedge clk);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask
  task automatic send5(input logic [7:0] a1, a0, op, b1, b0);
    put_byte(a1);
    put_byte(a0);
    put_byte(op);
    put_byte(b1);
    put_byte(b0);
  endtask
  task automatic expect_tx(input logic [7:0] exp, input string name, input bit poke_rx);
    int k = 0;
    while (bus.o_tx_start !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL %s tx_start missing: got %b want 1", name, bus.o_tx_start);
      return;
    end
    checks++;
    if (bus.o_tx_data !== exp) begin
      errors++;
      $display("FAIL %s tx_data got %h want %h", name, bus.o_tx_data, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL %s tx_start width: got %b want 0 on second cycle", name, bus.o_tx_start);
    end
    if (poke_rx) begin
      @(negedge clk);
      bus.i_rx_data = 8'h55;
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      bus.i_rx_done = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_tx_data !== exp || bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s hold: data %h start %b busy %b want %h 0 1", name, bus.o_tx_data, bus.o_tx_start, bus.o_busy, exp);
    end
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask
  task automatic expect_idle(input string name);
    int seen = 0;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy after frame: got %b want 0", name, bus.o_busy);
    end
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.o_tx_start !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s extra tx_start cycles: got %0d want 0", name, seen);
    end
  endtask
  task automatic test_reset;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_frame_err} !== 11'h0) begin
      errors++;
      $display("FAIL reset outputs: data %h start %b busy %b ferr %b want all 0", bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_add;
    send5(8'h12, 8'h34, 8'h2B, 8'h0F, 8'h0F);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL add exec cycle: busy %b start %b want 1 0", bus.o_busy, bus.o_tx_start);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL add latency: tx_start got %b want 1", bus.o_tx_start);
    end
    expect_tx(8'h21, "add_b0", 1'b0);
    expect_tx(8'h43, "add_b1", 1'b0);
    expect_idle("add");
  endtask
  task automatic test_sub_wrap;
    send5(8'h00, 8'h00, 8'h2D, 8'h00, 8'h01);
    expect_tx(8'hFF, "sub_b0", 1'b0);
    expect_tx(8'hFF, "sub_b1", 1'b0);
    expect_idle("sub");
  endtask
  task automatic test_srl;
    send5(8'h80, 8'h01, 8'h3E, 8'h00, 8'h04);
    expect_tx(8'h08, "srl_b0", 1'b0);
    expect_tx(8'h00, "srl_b1", 1'b0);
    expect_idle("srl");
  endtask
  task automatic test_invalid;
    send5(8'h00, 8'h05, 8'h41, 8'h00, 8'h03);
    expect_tx(8'hEE, "inv_err", 1'b0);
    expect_idle("inv");
  endtask
  task automatic test_timeout;
    int first = -1;
    int pulses = 0;
    put_byte(8'h12);
    for (int k = 1; k <= TO + 5; k++) begin
      @(posedge clk); #1;
      if (bus.o_frame_err === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL timeout pulse count got %0d want 1", pulses);
    end
    checks++;
    if (first != TO) begin
      errors++;
      $display("FAIL timeout pulse cycle got %0d want %0d", first, TO);
    end
    send5(8'h00, 8'h01, 8'h2B, 8'h00, 8'h01);
    expect_tx(8'h00, "to_next_b0", 1'b0);
    expect_tx(8'h02, "to_next_b1", 1'b0);
    expect_idle("to_next");
  endtask
  task automatic test_reset_mid_tx;
    int k = 0;
    send5(8'h12, 8'h34, 8'h2B, 8'h0F, 8'h0F);
    while (bus.o_tx_start !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid tx_wait: busy %b start %b want 1 0", bus.o_busy, bus.o_tx_start);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.i_tx_done = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_frame_err} !== 11'h0) begin
      errors++;
      $display("FAIL rst_mid outputs: data %h start %b busy %b ferr %b want all 0", bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid stale tx_done: busy %b start %b want 0 0", bus.o_busy, bus.o_tx_start);
      end
    end
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    send5(8'h0F, 8'hF0, 8'h5E, 8'hFF, 8'hFF);
    expect_tx(8'hF0, "xor_b0", 1'b0);
    expect_tx(8'h0F, "xor_b1", 1'b0);
    expect_idle("xor");
  endtask
  task automatic test_held_rx;
    @(negedge clk);
    bus.i_rx_data = 8'h07;
    bus.i_rx_done = 1'b1;
    repeat (10) @(negedge clk);
    bus.i_rx_done = 1'b0;
    put_byte(8'h0F);
    put_byte(8'h7C);
    put_byte(8'h00);
    put_byte(8'hF0);
    expect_tx(8'h07, "held_b0", 1'b1);
    expect_tx(8'hFF, "held_b1", 1'b0);
    expect_idle("held");
    send5(8'h00, 8'h01, 8'h3C, 8'h00, 8'h0F);
    expect_tx(8'h80, "sll_b0", 1'b0);
    expect_tx(8'h00, "sll_b1", 1'b0);
    expect_idle("sll");
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_srl();
    test_invalid();
    test_timeout();
    test_reset_mid_tx();
    test_held_rx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
